instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage directly upstream of the instruction decoder. Holds the PC and issues one-outstanding
//  reads to instruction memory. Buffers returned words with their PC in a small prefetch FIFO.
//  Presents them to decode over a valid/ready handshake; a redirect flushes the buffer and reloads the PC.
// PARAMETERS
//  RESET_PC    32'h0  PC loaded on reset
//  FIFO_DEPTH  2      prefetch entries (>=1)
//  ADDR_WIDTH  32     PC / imem address width
// PORTS
//  clk             in   1                   single clock, rising edge
//  reset_n         in   1                   asynchronous, active-low reset
//  imem_req        out  1                   read request; held high until imem_rvalid
//  imem_addr       out  ADDR_WIDTH          word-aligned read address; stable while imem_req
//  imem_rvalid     in   1                   read data valid; 1-cycle pulse per request
//  imem_rdata      in   INSTRUCTION_WIDTH   returned instruction word
//  instr_out       out  INSTRUCTION_WIDTH   head-of-FIFO instruction to decoder
//  instr_pc        out  ADDR_WIDTH          PC of instr_out
//  instr_valid     out  1                   FIFO non-empty
//  instr_ready     in   1                   decoder accepts; pop on instr_valid&&instr_ready
//  redirect_valid  in   1                   branch/jump redirect
//  redirect_pc     in   ADDR_WIDTH          redirect target
//  fetch_error     out  1                   sticky misalignment error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, reset_n=0): pc=RESET_PC, FIFO empty, state=RUN, imem_req=0, instr_valid=0, fetch_error=0.
//    instr_out/instr_pc/imem_addr read 0.
//  - States: RUN (no request outstanding), WAIT (request outstanding), DROP (outstanding response to discard),
//    HALT (error; only with macro). imem_req = (state==WAIT || state==DROP).
//  - RUN: if count<FIFO_DEPTH, register imem_addr=pc, go to WAIT.
//    First imem_req is 1 cycle after reset release.
//  - WAIT, imem_rvalid=1: push {imem_rdata, imem_addr}; pc=pc+4 (mod 2^ADDR_WIDTH).
//    If count+1-pop < FIFO_DEPTH, issue next address same edge and stay in WAIT (back-to-back); else go to RUN.
//  - Latency: imem_rvalid in cycle N -> instr_valid=1 in N+1.
//    Peak throughput is 1 instr/cycle with zero-wait memory.
//  - Occupancy: count + outstanding never exceeds FIFO_DEPTH, so no overflow.
//    Push and pop in the same cycle leave count unchanged.
//  - Redirect takes priority over push and pop. FIFO flushes on that edge (instr_valid=0 next cycle); pc=redirect_pc.
//    - From WAIT with imem_rvalid=0: go to DROP.
//    - From WAIT with imem_rvalid=1: data discarded; go to RUN.
//    - From RUN: stay in RUN.
//  - DROP: the next imem_rvalid is discarded -> RUN. A redirect in DROP updates pc only and stays in DROP.
//  - A decoder pop in the redirect cycle is ignored (entry flushed).
//  - imem_rvalid in RUN or HALT is ignored.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//    - redirect_pc[1:0]!=0 sets fetch_error=1 next cycle, flushes the FIFO, enters HALT.
//    - HALT: no requests; an outstanding response is discarded; instr_valid=0. Only reset clears it.
//  FETCH_ALIGN_CHECK_EN undefined: redirect_pc[1:0] is forced to 2'b00; fetch_error tied 0; HALT unused.
// STRUCTURE
//  - globalVariables.v adds: `ADDR_WIDTH, `PC_INCREMENT (4), fetch state codes `FETCH_RUN/WAIT/DROP/HALT
//    (2-bit).
//  - Sub-module fetch_fifo: sync FIFO, params DEPTH/WIDTH, ports push/pop/flush/full/empty/count;
//    flush beats push.
//  - Top: PC register, state machine, issue logic, redirect/align check.
// TESTING
//  1 Reset, zero-wait memory (rvalid 1 cycle after req), ready=1 ->
//    imem_addr 0,4,8,...; instr_pc follows 1 cycle after each rvalid; no bubbles after fill.
//  2 ready=0 with FIFO_DEPTH=2 -> exactly 2 pushes (pc 0,4), imem_req low.
//    Ready high 1 cycle -> pop pc 0, one new req addr 8.
//  3 Redirect to 0x100 while req to 0x8 outstanding, rvalid 3 cycles later ->
//    that word dropped; next req addr 0x100; first instr_pc=0x100.
//  4 Redirect coincident with rvalid and instr_valid&&ready ->
//    FIFO empty next cycle, data dropped, no double pop; next addr = target.
//  5 With FETCH_ALIGN_CHECK_EN: redirect to 0x102 -> fetch_error=1, imem_req stays 0, instr_valid=0
//    until reset_n pulse. Without: fetch from 0x100.
//  6 Assert reset_n=0 mid-WAIT -> all outputs return to reset values immediately (async);
//    after release, the first req is to RESET_PC and a stale rvalid is ignored.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and fetch state encoding for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int PC_INCREMENT      = 4;

    // RUN: idle, WAIT: request outstanding, DROP: outstanding response is stale, HALT: error stop
    typedef enum logic [1:0] {
        FETCH_RUN  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and redirect.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 32
);
    import instruction_fetch_pkg::*;

    logic                         imem_req;
    logic [ADDR_WIDTH-1:0]        imem_addr;
    logic                         imem_rvalid;
    logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
    logic [INSTRUCTION_WIDTH-1:0] instr_out;
    logic [ADDR_WIDTH-1:0]        instr_pc;
    logic                         instr_valid;
    logic                         instr_ready;
    logic                         redirect_valid;
    logic [ADDR_WIDTH-1:0]        redirect_pc;
    logic                         fetch_error;

    modport master (
        output imem_req, imem_addr, instr_out, instr_pc, instr_valid, fetch_error,
        input  imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, instr_pc, instr_valid, fetch_error,
        output imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO for prefetched {instruction, pc} entries; flush beats push.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer/count update; pointers wrap at DEPTH so non-power-of-two depths work
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = wdata;
                wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, one-outstanding fetch FSM and prefetch buffer feeding decode.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target raises a sticky fetch_error
// and parks the stage in HALT until reset; without it the target's low two bits are dropped.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    instruction_fetch_if.master bus
);
    localparam int EW = INSTRUCTION_WIDTH + ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, pc_inc, tgt_pc;
    logic                  err_q, err_d;
    logic                  redir, misalign, push, pop, flush, empty, full;
    logic [CW-1:0]         count;
    logic [CW:0]           occ_next;
    logic [EW-1:0]         head;

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt_pc   = bus.redirect_pc;
    assign misalign = (bus.redirect_pc[1:0] != 2'b00);
`else
    logic [1:0] unused_redirect_lsb;
    assign unused_redirect_lsb = bus.redirect_pc[1:0];
    assign tgt_pc   = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign misalign = 1'b0;
`endif

    // Redirects are ignored once halted; a redirect cancels any pop in the same cycle
    assign redir    = bus.redirect_valid && (state_q != FETCH_HALT);
    assign pop      = !empty && bus.instr_ready && !redir;
    assign occ_next = {1'b0, count} + {{CW{1'b0}}, ~pop};
    assign pc_inc   = pc_q + ADDR_WIDTH'(PC_INCREMENT);

    // Next-state, issue and push decisions; redirect overrides everything below it
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        err_d   = err_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            FETCH_RUN: begin
                if (!redir && !full) begin
                    addr_d  = pc_q;
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (redir) begin
                    state_d = bus.imem_rvalid ? FETCH_RUN : FETCH_DROP;
                end else if (bus.imem_rvalid) begin
                    push = 1'b1;
                    pc_d = pc_inc;
                    // Back-to-back issue only if the slot for the new request is free
                    if (occ_next < (CW + 1)'(FIFO_DEPTH)) addr_d = pc_inc;
                    else                                  state_d = FETCH_RUN;
                end
            end
            FETCH_DROP: begin
                if (bus.imem_rvalid) state_d = FETCH_RUN;
            end
            FETCH_HALT: ;
            default: state_d = FETCH_RUN;
        endcase
        if (redir) begin
            flush = 1'b1;
            pc_d  = tgt_pc;
            if (misalign) begin
                err_d   = 1'b1;
                state_d = FETCH_HALT;
            end
        end
    end

    // State, PC, issued address and sticky error registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH_RUN;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wdata   ({bus.imem_rdata, addr_q}),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign bus.imem_req                  = (state_q == FETCH_WAIT) || (state_q == FETCH_DROP);
    assign bus.imem_addr                 = addr_q;
    assign bus.instr_valid               = !empty;
    assign {bus.instr_out, bus.instr_pc} = empty ? '0 : head;
    assign bus.fetch_error               = err_q;

endmodule
